// File: rtl/pccmd_pkg.sv
// pccmd_pkg: state encoding, frame constants and boot table for the PC command sequencer
package pccmd_pkg;
  typedef logic [2:0] state_t;
  localparam state_t ST_BOOT     = 3'd0;
  localparam state_t ST_IDLE     = 3'd1;
  localparam state_t ST_COLLECT  = 3'd2;
  localparam state_t ST_CHECK    = 3'd3;
  localparam state_t ST_ISSUE    = 3'd4;
  localparam state_t ST_WAIT_ACK = 3'd5;
  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam logic [7:0] MAX_PAIRS = 8'd4;
  localparam int BOOT_LEN = 3;
  // {addr, data}, written in index order
  localparam logic [15:0] BOOT_TABLE [BOOT_LEN] = '{16'h1280, 16'h0C04, 16'h3A0C};
endpackage

// File: rtl/pccmd_frame_buf.sv
// pccmd_frame_buf: command frame store with write index, running XOR and field checks
module pccmd_frame_buf import pccmd_pkg::*; #(
  parameter int FRAME_LEN = 11
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic       i_clr,
  input  logic [7:0] i_data,
  input  logic [1:0] i_k,
  output logic       o_last,
  output logic [2:0] o_n,
  output logic [7:0] o_pair_addr,
  output logic [7:0] o_pair_data,
  output logic       o_hdr_ok,
  output logic       o_cnt_ok,
  output logic       o_sum_ok
);
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);
  logic [7:0] r_mem [FRAME_LEN];
  logic [3:0] r_idx;
  logic [7:0] r_sum;
  logic [3:0] w_ai;
  always_ff @(posedge i_clk)
    if (i_we) r_mem[r_idx] <= i_data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_idx <= '0;
      r_sum <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
      r_sum <= '0;
    end else if (i_we) begin
      r_idx <= r_idx + 4'd1;
      r_sum <= r_sum ^ i_data;
    end
  // pair k occupies bytes 2+2k (addr) and 3+2k (data)
  assign w_ai        = {1'b0, i_k, 1'b0} + 4'd2;
  assign o_pair_addr = r_mem[w_ai];
  assign o_pair_data = r_mem[w_ai + 4'd1];
  assign o_last      = r_idx == LAST_IDX;
  assign o_n         = r_mem[1][2:0];
  assign o_hdr_ok    = r_mem[0] == FRAME_HDR;
  assign o_cnt_ok    = r_mem[1] != 8'd0 && r_mem[1] <= MAX_PAIRS;
  assign o_sum_ok    = r_sum == 8'd0;
endmodule

// File: rtl/pccmd_sched.sv
// pccmd_sched: frames PC command packets and sequences their register writes on a req/ack port
// Defining PCCMD_BOOTINIT_EN adds a boot-table replay ahead of PC traffic after reset.
module pccmd_sched import pccmd_pkg::*; #(
  parameter int GAP_TIMEOUT = 255,
  parameter int FRAME_LEN   = 11
) (
  input  logic       camclk,
  input  logic       camreset_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       reg_req,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  input  logic       reg_ack,
  output logic       busy,
  output logic       frame_ok,
  output logic [7:0] err_count
);
  localparam logic [7:0] GAP_LIM = 8'(GAP_TIMEOUT - 1);
`ifdef PCCMD_BOOTINIT_EN
  localparam state_t ST_RESET = ST_BOOT;
`else
  localparam state_t ST_RESET = ST_IDLE;
`endif
  state_t     r_state;
  logic [1:0] r_k;
  logic [7:0] r_gap, r_addr, r_data, r_err;
  logic       r_req, r_ovr, r_fok;
  logic       w_idle, w_collect, w_check, w_busy, w_we, w_at_last, w_last, w_to;
  logic       w_ok, w_err, w_ack, w_pair_last, w_hdr_ok, w_cnt_ok, w_sum_ok;
  logic [2:0] w_n;
  logic [7:0] w_pa, w_pd;
  pccmd_frame_buf #(.FRAME_LEN(FRAME_LEN)) u_buf (
    .i_clk(camclk), .i_rst_n(camreset_n), .i_we(w_we), .i_clr(w_check | w_to),
    .i_data(in_data), .i_k(r_k), .o_last(w_at_last), .o_n(w_n),
    .o_pair_addr(w_pa), .o_pair_data(w_pd),
    .o_hdr_ok(w_hdr_ok), .o_cnt_ok(w_cnt_ok), .o_sum_ok(w_sum_ok)
  );
  assign w_idle      = r_state == ST_IDLE;
  assign w_collect   = r_state == ST_COLLECT;
  assign w_check     = r_state == ST_CHECK;
  assign w_busy      = !(w_idle || w_collect);
  assign w_we        = in_valid & !w_busy;
  assign w_last      = in_valid & w_at_last;
  // the timeout fires on the GAP_TIMEOUT-th consecutive idle cycle
  assign w_to        = w_collect & !in_valid & (r_gap >= GAP_LIM);
  assign w_ok        = w_hdr_ok & w_cnt_ok & w_sum_ok;
  assign w_ack       = r_req & reg_ack;
  assign w_pair_last = {1'b0, r_k} == w_n - 3'd1;
  assign w_err       = (w_check & !w_ok) | w_to | (in_valid & w_busy & !r_ovr);
  assign reg_req     = r_req;
  assign reg_addr    = r_addr;
  assign reg_data    = r_data;
  assign busy        = w_busy;
  assign frame_ok    = r_fok;
  assign err_count   = r_err;
`ifdef PCCMD_BOOTINIT_EN
  logic [15:0] w_boot;
  logic        w_boot_last;
  assign w_boot      = BOOT_TABLE[r_k];
  assign w_boot_last = r_k == 2'(BOOT_LEN - 1);
`endif
  always_ff @(posedge camclk or negedge camreset_n)
    if (!camreset_n) begin
      r_state <= ST_RESET;
      r_k     <= '0;
      r_gap   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_err   <= '0;
      r_req   <= 1'b0;
      r_ovr   <= 1'b0;
      r_fok   <= 1'b0;
    end else begin
      r_fok <= w_check & w_ok;
      r_err <= (w_err && r_err != 8'hFF) ? r_err + 8'd1 : r_err;
      r_ovr <= w_idle ? 1'b0 : r_ovr | (in_valid & w_busy);
      r_gap <= (w_collect && !in_valid && r_gap != 8'hFF) ? r_gap + 8'd1 : 8'd0;
      case (r_state)
        ST_IDLE:    r_state <= in_valid ? ST_COLLECT : ST_IDLE;
        ST_COLLECT: r_state <= w_to ? ST_IDLE : w_last ? ST_CHECK : ST_COLLECT;
        ST_CHECK: begin
          r_state <= w_ok ? ST_ISSUE : ST_IDLE;
          if (w_ok) begin
            r_req  <= 1'b1;
            r_addr <= w_pa;
            r_data <= w_pd;
          end
        end
        // a request drops for one cycle after each ack before the next pair rises
        ST_ISSUE, ST_WAIT_ACK:
          if (w_ack) begin
            r_req   <= 1'b0;
            r_k     <= w_pair_last ? 2'd0 : r_k + 2'd1;
            r_state <= w_pair_last ? ST_IDLE : ST_ISSUE;
          end else if (!r_req) begin
            r_req   <= 1'b1;
            r_addr  <= w_pa;
            r_data  <= w_pd;
            r_state <= ST_WAIT_ACK;
          end else r_state <= ST_WAIT_ACK;
`ifdef PCCMD_BOOTINIT_EN
        ST_BOOT:
          if (w_ack) begin
            r_req   <= 1'b0;
            r_k     <= w_boot_last ? 2'd0 : r_k + 2'd1;
            r_state <= w_boot_last ? ST_IDLE : ST_BOOT;
          end else if (!r_req) begin
            r_req  <= 1'b1;
            r_addr <= w_boot[15:8];
            r_data <= w_boot[7:0];
          end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_pccmd_sched.sv
// tb_pccmd_sched: randomized scoreboard bench for pccmd_sched against a frame-level reference model
module tb_pccmd_sched;
  import pccmd_pkg::*;
  localparam int GAP = 255;
  typedef logic [7:0] frame_t [11];
  logic       camclk = 1'b0, camreset_n = 1'b0, in_valid = 1'b0, reg_ack = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       reg_req, busy, frame_ok;
  logic [7:0] reg_addr, reg_data, err_count;
  int          checks = 0, errors = 0, fok_pend = 0, model_err = 0;
  bit          slow = 1'b0;
  logic [15:0] exp_q [$];

  always #5 camclk = ~camclk;

  pccmd_sched #(.GAP_TIMEOUT(GAP), .FRAME_LEN(11)) dut (
    .camclk(camclk), .camreset_n(camreset_n), .in_valid(in_valid), .in_data(in_data),
    .reg_req(reg_req), .reg_addr(reg_addr), .reg_data(reg_data), .reg_ack(reg_ack),
    .busy(busy), .frame_ok(frame_ok), .err_count(err_count)
  );

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge camclk);
    #1;
    in_valid = v;
    in_data  = d;
  endtask

  function automatic frame_t fix_sum(input frame_t f);
    frame_t  g = f;
    logic [7:0] x = 8'd0;
    for (int i = 0; i < 10; i++) x ^= g[i];
    g[10] = x;
    return g;
  endfunction

  function automatic frame_t mk(input logic [7:0] hdr, input logic [7:0] n, input logic bad);
    frame_t f;
    f[0] = hdr;
    f[1] = n;
    for (int i = 2; i < 11; i++) f[i] = 8'($urandom);
    f = fix_sum(f);
    f[10] ^= {7'd0, bad};
    return f;
  endfunction

  // reference: a frame is good iff header, pair count and whole-frame XOR are right
  task automatic model(input frame_t f);
    logic [7:0] x = 8'd0;
    for (int i = 0; i < 11; i++) x ^= f[i];
    if (f[0] == 8'hA5 && f[1] >= 8'd1 && f[1] <= 8'd4 && x == 8'd0) begin
      fok_pend++;
      for (int k = 0; k < int'(f[1]); k++) exp_q.push_back({f[2+2*k], f[3+2*k]});
    end else if (model_err < 255) model_err++;
  endtask

  task automatic send_frame(input frame_t f, input bit rnd, input int gap_at, input int gap_len);
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, f[i]);
      if (i == gap_at) repeat (gap_len) drive(1'b0, 8'd0);
      else if (rnd && i < 10) repeat ($urandom_range(0, 2)) drive(1'b0, 8'd0);
    end
    drive(1'b0, 8'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      @(posedge camclk);
      #1;
      n++;
    end
    if (n >= 5000) check("idle_timeout", 1, 0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!reg_req && n < 200) begin
      @(posedge camclk);
      #1;
      n++;
    end
    check("req_seen", int'(reg_req), 1);
  endtask

  task automatic end_check(input string nm);
    wait_idle();
    repeat (2) @(posedge camclk);
    #1;
    check({nm, "_err"}, int'(err_count), model_err);
    check({nm, "_pending_wr"}, exp_q.size(), 0);
    check({nm, "_pending_fok"}, fok_pend, 0);
  endtask

  task automatic after_reset();
`ifdef PCCMD_BOOTINIT_EN
    for (int i = 0; i < BOOT_LEN; i++) exp_q.push_back(BOOT_TABLE[i]);
`endif
    wait_idle();
  endtask

  // ack responder: random or slow delay once reg_req is seen, spurious acks while it is low
  initial begin
    int cnt = 0, dly = 0;
    forever begin
      @(posedge camclk);
      #1;
      if (reg_req) begin
        if (cnt >= dly) reg_ack = 1'b1;
        else begin
          reg_ack = 1'b0;
          cnt++;
        end
      end else begin
        reg_ack = ($urandom_range(0, 3) == 0);
        cnt = 0;
        dly = slow ? 20 : int'($urandom_range(0, 3));
      end
    end
  end

  // monitor: every accepted write is popped from the scoreboard and compared
  initial begin
    logic        prev_req = 1'b0, prev_hs = 1'b0;
    logic [15:0] held = 16'd0;
    forever begin
      @(negedge camclk);
      if (!camreset_n) begin
        prev_req = 1'b0;
        prev_hs  = 1'b0;
        continue;
      end
      if (prev_hs) check("req_drop", int'(reg_req), 0);
      if (reg_req && !prev_req) held = {reg_addr, reg_data};
      if (frame_ok) begin
        check("fok_with_req", int'(reg_req), 1);
        if (fok_pend == 0) check("fok_unexpected", 1, 0);
        else fok_pend--;
      end
      prev_hs = reg_req && reg_ack;
      if (prev_hs) begin
        check("addr_data_hold", int'({reg_addr, reg_data}), int'(held));
        if (exp_q.size() == 0) check("unexpected_write", int'({reg_addr, reg_data}), -1);
        else check("write", int'({reg_addr, reg_data}), int'(exp_q.pop_front()));
      end
      prev_req = reg_req;
    end
  end

  initial begin
    frame_t f, fp;
    logic [7:0] n;
    int r;
    repeat (3) @(posedge camclk);
    #1;
    check("rst_req", int'(reg_req), 0);
    check("rst_addr", int'(reg_addr), 0);
    check("rst_data", int'(reg_data), 0);
    check("rst_fok", int'(frame_ok), 0);
    check("rst_err", int'(err_count), 0);
`ifdef PCCMD_BOOTINIT_EN
    check("rst_busy", int'(busy), 1);
`else
    check("rst_busy", int'(busy), 0);
`endif
    camreset_n = 1'b1;
    after_reset();
    // plan frame with latency checks
    fp = '{8'hA5, 8'h02, 8'h10, 8'h80, 8'h11, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fp = fix_sum(fp);
    model(fp);
    send_frame(fp, 1'b0, -1, 0);
    check("lat_t1_fok", int'(frame_ok), 0);
    check("lat_t1_busy", int'(busy), 1);
    @(posedge camclk);
    #1;
    check("lat_t2_fok", int'(frame_ok), 1);
    check("lat_t2_req", int'(reg_req), 1);
    check("lat_t2_addr", int'(reg_addr), 8'h10);
    end_check("valid");
    // bad checksum
    f = fp;
    f[10] ^= 8'h01;
    model(f);
    send_frame(f, 1'b0, -1, 0);
    check("badsum_t1_busy", int'(busy), 1);
    @(posedge camclk);
    #1;
    check("badsum_t2_busy", int'(busy), 0);
    check("badsum_t2_req", int'(reg_req), 0);
    end_check("badsum");
    // pair count out of range
    f = mk(8'hA5, 8'd0, 1'b0);
    model(f);
    send_frame(f, 1'b1, -1, 0);
    end_check("n0");
    f = mk(8'hA5, 8'd5, 1'b0);
    model(f);
    send_frame(f, 1'b1, -1, 0);
    end_check("n5");
    // gap timeout, then a full frame
    f = mk(8'hA5, 8'd3, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, f[i]);
    repeat (GAP) drive(1'b0, 8'd0);
    model_err++;
    f = mk(8'hA5, 8'd4, 1'b0);
    model(f);
    send_frame(f, 1'b0, -1, 0);
    end_check("gap");
    // a gap one cycle short of the timeout is tolerated
    f = mk(8'hA5, 8'd2, 1'b0);
    model(f);
    send_frame(f, 1'b0, 4, GAP - 1);
    end_check("gap_edge");
    // overrun during a slow ack
    slow = 1'b1;
    f = mk(8'hA5, 8'd2, 1'b0);
    model(f);
    send_frame(f, 1'b0, -1, 0);
    wait_req();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'($urandom));
      drive(1'b0, 8'd0);
    end
    model_err++;
    wait_idle();
    slow = 1'b0;
    end_check("overrun");
    // randomized frames
    for (int it = 0; it < 25; it++) begin
      r = $urandom_range(0, 9);
      n = (r < 8) ? 8'($urandom_range(1, 4)) : 8'($urandom);
      f = mk((r == 9) ? 8'hA5 ^ 8'($urandom_range(1, 255)) : 8'hA5, n, r == 8);
      model(f);
      send_frame(f, 1'b1, -1, 0);
      end_check("random");
    end
    // asynchronous reset while a request is pending
    slow = 1'b1;
    f = mk(8'hA5, 8'd3, 1'b0);
    model(f);
    send_frame(f, 1'b0, -1, 0);
    wait_req();
    @(posedge camclk);
    #3;
    camreset_n = 1'b0;
    #1;
    check("async_rst_req", int'(reg_req), 0);
    exp_q.delete();
    fok_pend = 0;
    model_err = 0;
    slow = 1'b0;
    @(posedge camclk);
    #1;
    camreset_n = 1'b1;
    after_reset();
    check("post_rst_err", int'(err_count), 0);
    f = mk(8'hA5, 8'd1, 1'b0);
    model(f);
    send_frame(f, 1'b1, -1, 0);
    end_check("post_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
